// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port byte-wide memory controller arbitrating i-cache line refills and LSB loads/stores.
// Ports:
//   clk, rst (async, active-high), rdy (global enable), rollback (ROB flush)
//   if_en/if_pc -> if_done/if_data             : 64-byte line refill
//   lsb_en/lsb_wr/lsb_addr/lsb_len/lsb_w_data
//     -> lsb_done/lsb_r_data                    : 1/2/4-byte load or store
//   mem_din -> mem_dout/mem_a/mem_wr            : RAM/IO pins (read data lags address by one cycle)
//   io_buffer_full                              : stalls stores that target the IO range
// Macro MEMCTRL_FAIR_ARB_EN: alternate grants when both requesters are pending;
//   undefined, the LSB always wins.
module mem_ctrl #(
  parameter int ICACHE_BLK_BYTES = 64,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          rollback,
  input  logic                          if_en,
  input  logic [31:0]                   if_pc,
  output logic                          if_done,
  output logic [8*ICACHE_BLK_BYTES-1:0] if_data,
  input  logic                          lsb_en,
  input  logic                          lsb_wr,
  input  logic [31:0]                   lsb_addr,
  input  logic [2:0]                    lsb_len,
  input  logic [31:0]                   lsb_w_data,
  output logic                          lsb_done,
  output logic [31:0]                   lsb_r_data,
  input  logic [7:0]                    mem_din,
  output logic [7:0]                    mem_dout,
  output logic [31:0]                   mem_a,
  output logic                          mem_wr,
  input  logic                          io_buffer_full
);
  typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;
  localparam int CW = $clog2(ICACHE_BLK_BYTES + 2);
  localparam int SW = $clog2(ICACHE_BLK_BYTES);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, len, len_n;
  logic [31:0] base, base_n, wbuf, wbuf_n, wa, mem_a_n, lsb_r_data_n;
  logic [7:0] mem_dout_n, wbyte;
  logic [8*ICACHE_BLK_BYTES-1:0] if_data_n;
  logic mem_wr_n, if_done_n, lsb_done_n;
  logic pick_ls, go_ls, go_if, stall, wr_go;
`ifdef MEMCTRL_FAIR_ARB_EN
  // last_grant: 1 = LSB, 0 = IF; only the alternating policy consumes it
  logic last_ls;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_ls <= 1'b0;
    else if (rdy & (go_ls | go_if)) last_ls <= go_ls;
  assign pick_ls = lsb_en & (~if_en | ~last_ls);
`else
  assign pick_ls = lsb_en;
`endif
  assign go_ls = state == IDLE & ~rollback & pick_ls;
  assign go_if = state == IDLE & ~rollback & if_en & ~pick_ls;
  // cnt is always 0 in IDLE, so the grant cycle and LS_WR share the write-issue path
  assign wa = (state == IDLE ? lsb_addr : base) + 32'(cnt);
  assign wbyte = 8'((state == IDLE ? lsb_w_data : wbuf) >> {cnt[1:0], 3'b000});
  assign stall = io_buffer_full & wa >= IO_BASE & wa <= 32'h3FFFF;
  assign wr_go = (go_ls & lsb_wr | state == LS_WR & cnt != len) & ~stall;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    len_n = len;
    base_n = base;
    wbuf_n = wbuf;
    mem_a_n = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n = 1'b0;
    if_done_n = 1'b0;
    lsb_done_n = 1'b0;
    if_data_n = if_data;
    lsb_r_data_n = lsb_r_data;
    if (wr_go) begin
      mem_a_n = wa;
      mem_dout_n = wbyte;
      mem_wr_n = 1'b1;
      cnt_n = cnt + CW'(1);
    end
    case (state)
      IDLE: if (go_ls | go_if) begin
        base_n = go_ls ? lsb_addr : if_pc;
        len_n = go_ls ? CW'(lsb_len) : CW'(ICACHE_BLK_BYTES);
        wbuf_n = lsb_w_data;
        state_n = go_if ? IF_RD : lsb_wr ? LS_WR : LS_RD;
        if (go_if | ~lsb_wr) begin
          mem_a_n = base_n;
          cnt_n = CW'(1);
        end
        if (go_ls & ~lsb_wr) lsb_r_data_n = 32'h0;
      end
      // cnt counts addresses issued; the byte for address k is on mem_din when cnt = k+2
      IF_RD, LS_RD: if (rollback) begin
        state_n = IDLE;
        cnt_n = '0;
      end else begin
        if (cnt < len) mem_a_n = base + 32'(cnt);
        if (cnt >= CW'(2)) begin
          if (state == IF_RD) if_data_n[{SW'(cnt - CW'(2)), 3'b000} +: 8] = mem_din;
          else lsb_r_data_n[{2'(cnt - CW'(2)), 3'b000} +: 8] = mem_din;
        end
        if (cnt == len + CW'(1)) begin
          if_done_n = state == IF_RD;
          lsb_done_n = state == LS_RD;
          state_n = DONE;
          cnt_n = '0;
        end else cnt_n = cnt + CW'(1);
      end
      LS_WR: if (cnt == len) begin
        lsb_done_n = 1'b1;
        state_n = DONE;
        cnt_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      base <= '0;
      wbuf <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if_data <= '0;
      lsb_r_data <= '0;
    end else if (rdy) begin
      state <= state_n;
      cnt <= cnt_n;
      len <= len_n;
      base <= base_n;
      wbuf <= wbuf_n;
      mem_a <= mem_a_n;
      mem_dout <= mem_dout_n;
      mem_wr <= mem_wr_n;
      if_done <= if_done_n;
      lsb_done <= lsb_done_n;
      if_data <= if_data_n;
      lsb_r_data <= lsb_r_data_n;
    end else begin
      mem_wr <= 1'b0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a byte-array RAM model
module tb_mem_ctrl;
  logic clk = 0, rst = 1, rdy = 1, rollback = 0;
  logic if_en = 0, if_done;
  logic [31:0] if_pc = 0;
  logic [511:0] if_data;
  logic lsb_en = 0, lsb_wr = 0, lsb_done;
  logic [31:0] lsb_addr = 0, lsb_w_data = 0, lsb_r_data;
  logic [2:0] lsb_len = 0;
  logic [7:0] mem_din = 0, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr, io_buffer_full = 0;
  int vecs = 0, errs = 0, n_ifd = 0;
  logic [7:0] wmem [logic [31:0]];
  logic [39:0] wlog [$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return wmem.exists(a) ? wmem[a] : a[7:0];
  endfunction

  always @(posedge clk) begin
    if (mem_wr) begin
      wmem[mem_a] = mem_dout;
      wlog.push_back({mem_a, mem_dout});
    end
    mem_din <= ram_rd(mem_a);
  end

  always @(negedge clk) if (if_done) n_ifd++;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_refill(input logic [31:0] pc);
    logic [511:0] e;
    int c;
    for (int i = 0; i < 64; i++) e[8*i +: 8] = ram_rd(pc + i);
    if_pc = pc;
    if_en = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c <= 64 && !if_done) chk("rf_addr", mem_a, pc + c - 1);
    end while (!if_done && c < 200);
    if_en = 0;
    chk("rf_lat", c, 66);
    chk("rf_data", if_data, e);
    @(negedge clk);
    chk("rf_pulse", if_done, 0);
  endtask

  task automatic do_load(input logic [31:0] a, input int n);
    logic [31:0] e;
    int c;
    e = 0;
    for (int i = 0; i < n; i++) e[8*i +: 8] = ram_rd(a + i);
    lsb_wr = 0;
    lsb_addr = a;
    lsb_len = 3'(n);
    lsb_en = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (c <= n && !lsb_done) chk("ld_addr", mem_a, a + c - 1);
    end while (!lsb_done && c < 200);
    lsb_en = 0;
    chk("ld_lat", c, n + 2);
    chk("ld_data", lsb_r_data, e);
    @(negedge clk);
    chk("ld_pulse", lsb_done, 0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int n, input int nst,
                          input bit noise, input int rb_at, input int rdy_at, input int rdy_len);
    int c;
    bit seen;
    wlog.delete();
    lsb_wr = 1;
    lsb_addr = a;
    lsb_w_data = d;
    lsb_len = 3'(n);
    lsb_en = 1;
    io_buffer_full = nst > 0 || (noise && $urandom_range(1) == 1);
    c = 0;
    seen = 0;
    while (!seen && c < 300) begin
      @(negedge clk);
      c++;
      if (c <= nst) chk("st_stall", mem_wr, 0);
      if (lsb_done) seen = 1;
      else begin
        io_buffer_full = c < nst || (noise && $urandom_range(1) == 1);
        rollback = c == rb_at;
        rdy = !(c >= rdy_at && c < rdy_at + rdy_len);
      end
    end
    lsb_en = 0;
    rollback = 0;
    rdy = 1;
    io_buffer_full = 0;
    chk("st_lat", c, n + 1 + nst + rdy_len);
    chk("st_nwr", wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size(); i++) chk("st_byte", wlog[i], {a + i, d[8*i +: 8]});
    @(negedge clk);
    chk("st_pulse", lsb_done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_if_done", if_done, 0);
    chk("rst_lsb_done", lsb_done, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_lsb_r_data", lsb_r_data, 0);
    chk("rst_if_data", if_data, 0);
    rst = 0;
    @(negedge clk);

    do_refill(32'h1000);
    wmem[32'h2002] = 8'h11;
    wmem[32'h2003] = 8'h22;
    wmem[32'h2004] = 8'h33;
    wmem[32'h2005] = 8'h44;
    do_load(32'h2002, 4);
    chk("ld4_lit", lsb_r_data, 32'h44332211);
    do_load(32'h2002, 1);
    chk("ld1_lit", lsb_r_data, 32'h00000011);

    for (int r = 0; r < 3; r++) begin
      bit exp_ls, got_ls;
      int c;
      logic [31:0] el;
`ifdef MEMCTRL_FAIR_ARB_EN
      exp_ls = r != 1;
`else
      exp_ls = 1;
`endif
      el = 0;
      for (int i = 0; i < 4; i++) el[8*i +: 8] = ram_rd(32'h2002 + i);
      if_pc = 32'h4000;
      if_en = 1;
      lsb_wr = 0;
      lsb_addr = 32'h2002;
      lsb_len = 3'd4;
      lsb_en = 1;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!if_done && !lsb_done && c < 200);
      got_ls = lsb_done;
      chk("arb_grant", got_ls, exp_ls);
      chk("arb_lat", c, got_ls ? 6 : 66);
      if (got_ls) chk("arb_ld", lsb_r_data, el);
      if_en = 0;
      lsb_en = 0;
      @(negedge clk);
    end

    do_store(32'h30000, 32'h0000BEEF, 2, 3, 0, -1, 0, 0);
    chk("io_b0", wmem[32'h30000], 8'hEF);
    chk("io_b1", wmem[32'h30001], 8'hBE);

    begin
      int dn;
      dn = n_ifd;
      if_pc = 32'h5000;
      if_en = 1;
      repeat (21) @(negedge clk);
      chk("rb_at20", mem_a, 32'h5014);
      rollback = 1;
      if_en = 0;
      @(negedge clk);
      rollback = 0;
      do_load(32'h2002, 2);
      repeat (70) @(negedge clk);
      chk("rb_no_done", n_ifd, dn);
    end
    do_store(32'h1100, 32'h89ABCDEF, 4, 0, 0, 2, 0, 0);
    do_store(32'h1180, 32'h13572468, 4, 0, 0, -1, 2, 2);

    lsb_wr = 1;
    lsb_addr = 32'h1200;
    lsb_w_data = 32'hCAFEF00D;
    lsb_len = 3'd4;
    lsb_en = 1;
    repeat (2) @(negedge clk);
    chk("ar_pre_wr", mem_wr, 1);
    #2 rst = 1;
    #1;
    chk("ar_mem_wr", mem_wr, 0);
    chk("ar_mem_a", mem_a, 0);
    chk("ar_lsb_done", lsb_done, 0);
    chk("ar_if_done", if_done, 0);
    lsb_en = 0;
    @(negedge clk);
    rst = 0;
    do_load(32'h1200, 2);

    for (int k = 0; k < 30; k++) begin
      int op, n;
      logic [31:0] a;
      op = $urandom_range(3);
      n = 1 << $urandom_range(2);
      case (op)
        0: do_refill($urandom & 32'hFFFF_FFC0);
        1: do_load($urandom, n);
        2: begin
          a = ($urandom_range(1) == 1 ? 32'h40000 : 32'h0) | ($urandom & 32'h1FFF0);
          do_store(a, $urandom, n, 0, 1, -1, 0, 0);
        end
        default: begin
          a = 32'h30000 | ($urandom & 32'hFFF0);
          do_store(a, $urandom, n, $urandom_range(3), 0, -1, 0, 0);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between instruction fetch and the load/store buffer (LSB). Shares the core's byte-wide RAM/IO port between the i-cache line-refill requester and the LSB data requester. Sequences multi-byte bursts, assembles read data, serialises writes, and handles rollback and the IO-buffer-full condition. Sits between the IFetch/LSB units and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

## Interface
- `ICACHE_BLK_BYTES`, 64, bytes per i-cache line refill; `if_data` width is 8×this.
- `IO_BASE`, 32'h30000, first IO address; IO range is `[IO_BASE, 32'h3FFFF]`.
- Clock and reset are fixed: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global enable. Low means all state freezes.
- `rollback` in 1: ROB flush. Aborts in-flight fetches and loads.
- `if_en` in 1: line refill request. Held until `if_done`.
- `if_pc` in 32: line base address. Low 6 bits are zero.
- `if_done` out 1: one-cycle pulse. `if_data` is valid in this cycle.
- `if_data` out 512: refilled line. Byte i is at bits [8i+7:8i].
- `lsb_en` in 1: data request. Held until `lsb_done`.
- `lsb_wr` in 1: 1 = store, 0 = load.
- `lsb_addr` in 32: byte address.
- `lsb_len` in 3: byte count. Legal values are 1, 2 and 4.
- `lsb_w_data` in 32: store data, little-endian.
- `lsb_done` out 1: one-cycle completion pulse.
- `lsb_r_data` out 32: load data, zero-extended. Valid with `lsb_done`.
- `mem_din` in 8: RAM read byte. It carries the byte for the address presented in the previous cycle.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART output buffer full.

## Operation
- States:
  - IDLE: no transfer in progress.
  - IF_RD: i-cache line refill.
  - LS_RD: LSB load.
  - LS_WR: LSB store.
  - DONE: one-cycle cooldown. The controller ignores `*_en` here, so the requester can drop its request after the done pulse.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant per the arbitration policy in Configuration.
  - Record the grant in `last_grant`.
- Reads (IF_RD, LS_RD):
  - Byte counter `cnt` starts at 0.
  - Each active cycle: `mem_a = base + cnt`, `mem_wr = 0`, `cnt` increments.
  - Capture `mem_din` into byte slot `cnt-1` when `cnt ≥ 1`.
  - Once N bytes have been captured (N = `ICACHE_BLK_BYTES` or `lsb_len`), pulse done and go to DONE.
- Writes (LS_WR):
  - Each active cycle: `mem_wr = 1`, `mem_a = lsb_addr + cnt`, `mem_dout = lsb_w_data[8cnt+7:8cnt]`.
  - After byte `lsb_len-1`, pulse `lsb_done` next cycle and go to DONE.
- IO stall:
  - Applies in LS_WR when `io_buffer_full = 1` and the address is in the IO range.
  - Drive `mem_wr = 0` and hold `cnt`.
  - Resume on the first cycle `io_buffer_full = 0`.
- Rollback:
  - In IF_RD or LS_RD: abort and go to IDLE with no done pulse. `mem_wr = 0`.
  - In LS_WR: the store is committed, so it completes normally.
  - In IDLE: requests seen in the same cycle as rollback are not granted.
- `rdy = 0`: hold all registers and force `mem_wr = 0`. The current byte is re-issued when `rdy` returns.
- Address arithmetic is 32-bit modulo. A line refill never crosses a 64-byte boundary.

## Timing
- All outputs are registered.
- Reset values: `if_done`, `lsb_done`, `mem_wr` = 0; `mem_a`, `mem_dout`, `lsb_r_data`, `if_data` = 0; state = IDLE; `last_grant` = IF.
- Grant latency: request seen in IDLE at edge E0; first address is driven after E0.
- Line refill: `if_done` is high for one cycle, `ICACHE_BLK_BYTES+1` cycles after the first address (65 cycles by default), with no stalls.
- LSB load of n bytes: `lsb_done` arrives n+1 cycles after the first address.
- LSB store of n bytes: `lsb_done` arrives n cycles after the first write, plus stall cycles.
- The DONE state adds one cycle before the next grant. Back-to-back transfers therefore have a one-cycle bus gap.
- Done outputs are deasserted in every non-completion cycle.

## Configuration
- `MEMCTRL_FAIR_ARB_EN` defined: when both requesters are pending, grant the one not in `last_grant` (alternating).
- Undefined: fixed priority, LSB always wins. IF is served only when `lsb_en = 0` in IDLE.

## Test plan
- IF-only refill, `if_pc = 0x1000`, RAM byte k = k[7:0]:
  - `mem_a` sweeps 0x1000–0x103F.
  - `if_done` is a single pulse 65 cycles after the first address.
  - `if_data[7:0] = 0x00` and `if_data[511:504] = 0x3F`.
- LSB 4-byte load at 0x2002, RAM = 0x11,0x22,0x33,0x44:
  - `lsb_r_data = 0x44332211`.
  - `lsb_done` arrives 5 cycles after the first address.
  - A 1-byte load returns `0x00000011`.
- Simultaneous `if_en` and `lsb_en` in IDLE, three rounds:
  - With the macro: grants go LSB, IF, LSB (since `last_grant` resets to IF).
  - Without the macro: LSB every round while `lsb_en` is held.
- 2-byte store of 0xBEEF to 0x30000, `io_buffer_full = 1` for 3 cycles:
  - `mem_wr = 0` while the buffer is full.
  - Then 0xEF is written at 0x30000 and 0xBE at 0x30001.
  - `lsb_done` arrives after the second write.
- `rollback` asserted at byte 20 of a refill:
  - No `if_done`.
  - Back in IDLE the next cycle, and a new request is granted after that.
  - The same rollback during a store does not interrupt it; `lsb_done` still pulses.
- `rst` asserted asynchronously mid-LS_WR:
  - `mem_wr`, `mem_a` and both done outputs drop immediately.
  - State is IDLE on release.
